// File: rtl/trig_debouncer_if.sv
// Bus between the trigger debouncer and its environment: raw inputs in,
// conditioned trigger/data plus status out.
interface trig_debouncer_if #(
  parameter int unsigned PCNT_W = 8
) ();
  logic              btn_raw;
  logic              sw_raw;
  logic              trig;
  logic              data;
  logic              btn_level;
  logic [PCNT_W-1:0] press_cnt;

  modport master (
    output btn_raw, sw_raw,
    input  trig, data, btn_level, press_cnt
  );

  modport slave (
    input  btn_raw, sw_raw,
    output trig, data, btn_level, press_cnt
  );
endinterface

// File: rtl/trig_debouncer.sv
// Button synchroniser/debouncer: one trig pulse per accepted press, with the
// synchronised switch value captured into data alongside it.
module trig_debouncer #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PCNT_W     = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  trig_debouncer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              btn_m, btn_s, sw_m, sw_s;
  logic              at_last;

  logic              trig_q, data_q, level_q;
  logic [PCNT_W-1:0] press_q;
  logic              trig_nxt, data_nxt, level_nxt;
  logic [PCNT_W-1:0] press_nxt;

  assign at_last = (cnt == CNT_LAST);

  // Two-flop synchronisers for both asynchronous inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw_m  <= 1'b0;
      sw_s  <= 1'b0;
    end else begin
      btn_m <= bus.btn_raw;
      btn_s <= btn_m;
      sw_m  <= bus.sw_raw;
      sw_s  <= sw_m;
    end
  end

  // State, qualification counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      trig_q  <= 1'b0;
      data_q  <= 1'b0;
      level_q <= 1'b0;
      press_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      trig_q  <= trig_nxt;
      data_q  <= data_nxt;
      level_q <= level_nxt;
      press_q <= press_nxt;
    end
  end

  // Next state: a level change must persist DEB_CYCLES samples after entry
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s)       state_nxt = IDLE;
        else if (at_last) state_nxt = HELD;
        else              cnt_nxt   = cnt + CNT_W'(1);
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = REL_WAIT;
          cnt_nxt   = '0;
        end
      end
      REL_WAIT: begin
        if (btn_s)        state_nxt = HELD;
        else if (at_last) state_nxt = IDLE;
        else              cnt_nxt   = cnt + CNT_W'(1);
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode; only the PRESS_WAIT->HELD acceptance fires a trig
  always_comb begin
    trig_nxt  = 1'b0;
    data_nxt  = data_q;
    press_nxt = press_q;
    level_nxt = (state_nxt == HELD) || (state_nxt == REL_WAIT);
    if ((state == PRESS_WAIT) && btn_s && at_last) begin
      trig_nxt  = 1'b1;
      data_nxt  = sw_s;
      press_nxt = press_q + PCNT_W'(1);
    end
  end

  assign bus.trig      = trig_q;
  assign bus.data      = data_q;
  assign bus.btn_level = level_q;
  assign bus.press_cnt = press_q;

endmodule

// File: tb/tb_trig_debouncer.sv
// Self-checking bench for trig_debouncer: run-length reference model plus
// directed scenarios and a randomized bounce phase.
module tb_trig_debouncer;

  localparam int unsigned DEB    = 4;
  localparam int unsigned PCNT_W = 8;

  logic clk;
  logic reset_n;

  trig_debouncer_if #(.PCNT_W(PCNT_W)) bus ();

  trig_debouncer #(
    .DEB_CYCLES(DEB),
    .CNT_W     (16),
    .PCNT_W    (PCNT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int trig_seen   = 0;

  // Reference model: raw history for the 2-edge sync delay, then a debounced
  // level that flips after DEB+1 consecutive samples disagreeing with it.
  logic              bh1, bh2, sh1, sh2;
  logic              m_level, m_trig, m_data;
  int                m_run;
  logic [PCNT_W-1:0] m_press;

  task automatic model_edge(input logic btn, input logic sw, input logic rst);
    logic s, ss;
    if (!rst) begin
      bh1 = 0; bh2 = 0; sh1 = 0; sh2 = 0;
      m_level = 0; m_trig = 0; m_data = 0; m_run = 0; m_press = '0;
    end else begin
      s  = bh2;
      ss = sh2;
      bh2 = bh1; bh1 = btn;
      sh2 = sh1; sh1 = sw;
      m_trig = 0;
      if (s != m_level) begin
        m_run++;
        if (m_run == int'(DEB) + 1) begin
          m_level = s;
          m_run   = 0;
          if (s) begin
            m_trig  = 1;
            m_data  = ss;
            m_press = m_press + 8'd1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic check_outputs();
    vectors++;
    trig_seen += int'(bus.trig);
    assert (bus.trig === m_trig) else begin
      miscompares++;
      $error("FAIL trig: got %b want %b at %0t", bus.trig, m_trig, $time);
    end
    assert (bus.data === m_data) else begin
      miscompares++;
      $error("FAIL data: got %b want %b at %0t", bus.data, m_data, $time);
    end
    assert (bus.btn_level === m_level) else begin
      miscompares++;
      $error("FAIL btn_level: got %b want %b at %0t", bus.btn_level, m_level, $time);
    end
    assert (bus.press_cnt === m_press) else begin
      miscompares++;
      $error("FAIL press_cnt: got %0d want %0d at %0t", bus.press_cnt, m_press, $time);
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Drive away from the active edge, update the model on the edge, sample after it
  task automatic step(input logic btn, input logic sw, input logic rst);
    @(negedge clk);
    bus.btn_raw = btn;
    bus.sw_raw  = sw;
    reset_n     = rst;
    @(posedge clk);
    model_edge(btn, sw, rst);
    #1 check_outputs();
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
  endtask

  int t0, trig_at, rel_start, lvl_before, lvl_after;
  int run;
  logic b;

  initial begin
    reset_n     = 1'b0;
    bus.btn_raw = 1'b0;
    bus.sw_raw  = 1'b0;
    do_reset();
    expect_int("reset_press_cnt", int'(bus.press_cnt), 0);
    expect_int("reset_level", int'(bus.btn_level), 0);

    // Clean press: trig exactly once, after edge DEB+2
    t0 = trig_seen; trig_at = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b1);
      if (bus.trig && trig_at < 0) trig_at = i;
    end
    expect_int("clean_trig_edge", trig_at, int'(DEB) + 2);
    expect_int("clean_data", int'(bus.data), 1);
    expect_int("clean_level_held", int'(bus.btn_level), 1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1);
    expect_int("clean_trig_count", trig_seen - t0, 1);
    expect_int("clean_press_cnt", int'(bus.press_cnt), 1);
    expect_int("clean_level_released", int'(bus.btn_level), 0);

    // Press bounce: only the final long high run qualifies
    do_reset();
    t0 = trig_seen; trig_at = -1;
    for (int i = 0; i < 30; i++) begin
      b = (i < 3) || (i == 4) || (i == 5) || (i >= 7 && i < 17);
      step(b, 1'b0, 1'b1);
      if (bus.trig && trig_at < 0) trig_at = i;
    end
    expect_int("bounce_trig_edge", trig_at, 7 + int'(DEB) + 2);
    expect_int("bounce_trig_count", trig_seen - t0, 1);
    expect_int("bounce_press_cnt", int'(bus.press_cnt), 1);

    // Release bounce: glitch low while held must not retrigger or drop level
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
    t0 = trig_seen;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    expect_int("relbounce_level_glitch", int'(bus.btn_level), 1);
    lvl_before = -1; lvl_after = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (i == int'(DEB) + 1) lvl_before = int'(bus.btn_level);
      if (i == int'(DEB) + 2) lvl_after  = int'(bus.btn_level);
    end
    expect_int("relbounce_level_before_fall", lvl_before, 1);
    expect_int("relbounce_level_after_fall", lvl_after, 0);
    expect_int("relbounce_no_trig", trig_seen - t0, 0);
    expect_int("relbounce_press_cnt", int'(bus.press_cnt), 1);

    // Data capture: switch moves while held are ignored
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
    expect_int("data_first", int'(bus.data), 0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'(i % 2), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    expect_int("data_hold_during_toggle", int'(bus.data), 0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1);
    expect_int("data_second", int'(bus.data), 1);
    expect_int("data_press_cnt", int'(bus.press_cnt), 2);

    // Counter wrap across 256 presses
    do_reset();
    t0 = trig_seen;
    for (int n = 1; n <= 256; n++) begin
      for (int i = 0; i < 8; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
      if (n == 255) expect_int("wrap_cnt_255", int'(bus.press_cnt), 255);
    end
    expect_int("wrap_cnt_0", int'(bus.press_cnt), 0);
    expect_int("wrap_trig_total", trig_seen - t0, 256);

    // Reset mid-qualification aborts it; requalification restarts from scratch
    do_reset();
    t0 = trig_seen;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    expect_int("midreset_no_trig", trig_seen - t0, 0);
    expect_int("midreset_level", int'(bus.btn_level), 0);
    trig_at = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b1);
      if (bus.trig && trig_at < 0) trig_at = i;
    end
    expect_int("midreset_trig_edge", trig_at, int'(DEB) + 2);
    expect_int("midreset_trig_count", trig_seen - t0, 1);
    expect_int("midreset_press_cnt", int'(bus.press_cnt), 1);

    // Randomized bounce runs, random switch, occasional reset
    do_reset();
    run = 0; b = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (run == 0) begin
        b   = ~b;
        run = int'($urandom_range(1, 9));
      end
      run--;
      step(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 299) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trig_debouncer.md
Name: trig_debouncer

Overview:
- Upstream input-conditioning stage for the LED pattern detector.
- Takes a raw push-button (btn_raw) and a raw data switch (sw_raw), both asynchronous to clk.
- Synchronises and debounces the button, then emits a single-cycle trig pulse with the switch value captured in data.
- trig and data connect directly to the detector's trig and data inputs. press_cnt and btn_level are debug/status outputs.

Parameters:
- DEB_CYCLES, default 16: consecutive synchronised-stable cycles required to accept a press or a release. Legal range 1..2^CNT_W-1.
- CNT_W, default 16: debounce counter width. Must hold DEB_CYCLES-1.
- PCNT_W, default 8: width of the accepted-press counter.

Ports:
- clk, input, 1: system clock. All logic on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- btn_raw, input, 1: raw push-button, asynchronous, bouncy.
- sw_raw, input, 1: raw data switch, asynchronous.
- trig, output, 1: one-cycle pulse per accepted press.
- data, output, 1: switch value captured with the most recent trig. Held between trigs.
- btn_level, output, 1: debounced button level.
- press_cnt, output, PCNT_W: number of accepted presses, wrapping.

Behaviour:
- Reset (reset_n=0, async):
  - Both synchroniser stages = 0, state = IDLE, counter = 0.
  - trig = 0, data = 0, btn_level = 0, press_cnt = 0.
  - Reset asserted mid-debounce discards the qualification in progress. No trig is produced.
- Synchronisers:
  - Two-flop chains give btn_s and sw_s, each 2 cycles behind the raw input.
  - Only btn_s and sw_s are used downstream.
- FSM states: IDLE, PRESS_WAIT, HELD, REL_WAIT.
- IDLE:
  - btn_s=1 -> PRESS_WAIT, cnt<=0.
- PRESS_WAIT:
  - btn_s=0 -> IDLE (bounce rejected, no trig).
  - btn_s=1 and cnt==DEB_CYCLES-1 -> HELD, trig<=1, data<=sw_s, press_cnt<=press_cnt+1.
  - Otherwise cnt<=cnt+1.
- HELD:
  - btn_s=0 -> REL_WAIT, cnt<=0.
- REL_WAIT:
  - btn_s=1 -> HELD (release bounce rejected, no new trig).
  - btn_s=0 and cnt==DEB_CYCLES-1 -> IDLE.
  - Otherwise cnt<=cnt+1.
- Illegal state encoding -> IDLE, cnt<=0.
- trig:
  - Registered. High for exactly one cycle, the cycle in which state first reads HELD coming from PRESS_WAIT.
  - Never high on a REL_WAIT->HELD transition.
- Latency: if btn_raw is first sampled high at edge 0 and stays high, trig is high in the cycle following edge DEB_CYCLES+2.
- data:
  - Updated only together with trig.
  - sw_raw changes at any other time have no effect on data.
- btn_level: 1 in HELD and REL_WAIT, 0 in IDLE and PRESS_WAIT. Driven from registered state.
- press_cnt: increments by 1 per trig, modulo 2^PCNT_W (255->0 at default).
- Throughput: at most one trig per full press/release cycle. A continuously held button yields exactly one trig.

Test Plan (bench overrides DEB_CYCLES=4, other parameters default):
- Clean press:
  - Stimulus: sw_raw=1; btn_raw 0->1 at edge 0, held 20 cycles, then 0.
  - Response: exactly one trig pulse, in the cycle after edge 6; data=1; press_cnt=1; btn_level=1 from edge 6 until 4 stable-low cycles after btn_s falls. No second trig.
- Press bounce:
  - Stimulus: btn_raw high 3 cycles, low 1, high 2, low 1, then high 10.
  - Response: exactly one trig, 6 cycles after the start of the final high run; press_cnt=1.
- Release bounce:
  - Stimulus: while HELD, btn_raw low 2 cycles, high 3, then low.
  - Response: no extra trig; btn_level stays 1 through the glitch, falls after 4 stable-low synchronised cycles; press_cnt unchanged.
- Data capture:
  - Stimulus: press with sw_raw=0, then toggle sw_raw 0->1 while held; second press with sw_raw=1.
  - Response: data=0 after first trig and unchanged during the toggle; data=1 after second trig.
- Counter wrap:
  - Stimulus: 256 clean press/release sequences.
  - Response: 256 trig pulses total; press_cnt reads 255 after the 255th and 0 after the 256th.
- Reset mid-operation:
  - Stimulus: btn_raw held high; reset_n pulled low 2 cycles into PRESS_WAIT for 3 cycles, then released with the button still high.
  - Response: all outputs 0 during reset and no trig from the aborted qualification. One trig in the cycle after the 6th edge following reset_n deassertion; press_cnt=1.
